// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - per-turn pick/reveal/move controller for Chicken Cha Cha Cha
//
// Accepts one hidden-card pick per step and compares it with the tile ahead of
// the current chicken. It then either advances that chicken or ends the turn.
// It also holds all four chicken positions and detects the winner.
//
// Optional feature: define TURN_SEQ_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES clocks in WAIT_PICK without a pick.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin/restart a game (honoured in IDLE and WIN only)
//   cur_turn          current player index from the turn-rotation stage
//   pick_valid        one-cycle pick strobe; pick_face/track_face valid with it
//   pick_face         face code of the picked card
//   track_face        face code of the tile ahead of chicken cur_turn
//   next_turn_pulse   one-cycle end-of-turn strobe (high during END)
//   cur_pos           position of chicken cur_turn (combinational)
//   reveal            high while the picked card is displayed
//   matched           compare result of the last pick
//   winner_valid      high in WIN
//   winner_id         index of the winning player
//   state             FSM state code
module turn_sequencer #(
    parameter int TRACK_LEN      = 24,
    parameter int REVEAL_CYCLES  = 50_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cur_turn,
    input  logic       pick_valid,
    input  logic [3:0] pick_face,
    input  logic [3:0] track_face,
    output logic       next_turn_pulse,
    output logic [4:0] cur_pos,
    output logic       reveal,
    output logic       matched,
    output logic       winner_valid,
    output logic [1:0] winner_id,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PICK = 3'd1,
        S_REVEAL    = 3'd2,
        S_MOVE      = 3'd3,
        S_END       = 3'd4,
        S_SETTLE    = 3'd5,
        S_WIN       = 3'd6
    } state_t;

    // The reveal counter is loaded with REVEAL_CYCLES-1 and exits at zero,
    // so REVEAL lasts exactly REVEAL_CYCLES clocks.
    localparam int               RCW       = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [RCW-1:0]   RC_LOAD   = RCW'(REVEAL_CYCLES - 1);
    localparam logic [4:0]       LAST_TILE = 5'(TRACK_LEN - 1);

    state_t           state_q, state_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic [4:0]       pos_q [4];
    logic [4:0]       pos_d [4];
    logic             matched_q, matched_d;
    logic [1:0]       winner_id_q, winner_id_d;
    logic             reveal_q, next_turn_pulse_q, winner_valid_q;

`ifdef TURN_SEQ_TIMEOUT_EN
    localparam int             TOW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
    logic [TOW-1:0]            to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        pos_d       = pos_q;
        matched_d   = matched_q;
        winner_id_d = winner_id_q;
`ifdef TURN_SEQ_TIMEOUT_EN
        // Zero everywhere except while counting in WAIT_PICK, so every entry
        // to WAIT_PICK starts from a cleared count.
        to_cnt_d    = '0;
`endif
        case (state_q)
            S_IDLE, S_WIN: begin
                if (start) begin
                    pos_d       = '{default: '0};
                    winner_id_d = '0;
                    state_d     = S_WAIT_PICK;
                end
            end
            S_WAIT_PICK: begin
                // A pick on the expiry cycle takes priority over the timeout.
                if (pick_valid) begin
                    matched_d = (pick_face == track_face);
                    rcnt_d    = RC_LOAD;
                    state_d   = S_REVEAL;
                end
`ifdef TURN_SEQ_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    matched_d = 1'b0;
                    state_d   = S_END;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_REVEAL: begin
                if (rcnt_q == '0) begin
                    state_d = matched_q ? S_MOVE : S_END;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            S_MOVE: begin
                // Completing a lap wraps to tile 0 and wins the game.
                if (pos_q[cur_turn] == LAST_TILE) begin
                    pos_d[cur_turn] = '0;
                    winner_id_d     = cur_turn;
                    state_d         = S_WIN;
                end else begin
                    pos_d[cur_turn] = pos_q[cur_turn] + 5'd1;
                    state_d         = S_WAIT_PICK;
                end
            end
            S_END:    state_d = S_SETTLE;
            // One idle cycle lets the rotation stage present the new cur_turn.
            S_SETTLE: state_d = S_WAIT_PICK;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            rcnt_q            <= '0;
            for (int i = 0; i < 4; i++) pos_q[i] <= '0;
            matched_q         <= 1'b0;
            winner_id_q       <= '0;
            reveal_q          <= 1'b0;
            next_turn_pulse_q <= 1'b0;
            winner_valid_q    <= 1'b0;
`ifdef TURN_SEQ_TIMEOUT_EN
            to_cnt_q          <= '0;
`endif
        end else begin
            state_q           <= state_d;
            rcnt_q            <= rcnt_d;
            pos_q             <= pos_d;
            matched_q         <= matched_d;
            winner_id_q       <= winner_id_d;
            // Decoded from the next state so these flags align with state.
            reveal_q          <= (state_d == S_REVEAL);
            next_turn_pulse_q <= (state_d == S_END);
            winner_valid_q    <= (state_d == S_WIN);
`ifdef TURN_SEQ_TIMEOUT_EN
            to_cnt_q          <= to_cnt_d;
`endif
        end
    end

    assign cur_pos         = pos_q[cur_turn];
    assign reveal          = reveal_q;
    assign next_turn_pulse = next_turn_pulse_q;
    assign matched         = matched_q;
    assign winner_valid    = winner_valid_q;
    assign winner_id       = winner_id_q;
    assign state           = state_q;

endmodule
